// File: rtl/pcileech_sysctl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pcileech_sysctl_pkg
// Shared state type, 100 MHz default timings and helpers for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pcileech_sysctl_pkg;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_RUN     = 2'd1,
        S_HELD    = 2'd2,
        S_WAITREL = 2'd3
    } sysctl_state_t;

    localparam int c_def_debounce_cycles  = 1_000_000;
    localparam int c_def_rst_cycles       = 64;
    localparam int c_def_reload_cycles    = 500_000_000;
    localparam int c_def_blink_bit        = 24;
    localparam int c_def_blink_window_bit = 27;

    function automatic logic [63:0] sat_inc64(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcileech_sysctl_seq_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_btn_debounce
// 2-FF synchronizer plus debounce counter for one active-low push button.
// Revision : 1.0 - initial release
// ============================================================================
module pcileech_btn_debounce #(
    parameter int PARAM_DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_n_o
);

    localparam int                 c_cnt_w = $clog2(PARAM_DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PARAM_DEBOUNCE_CYCLES - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic               level_q;
    logic [c_cnt_w-1:0] cnt_q;

    // The counter only runs while the synchronized pin disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == c_last) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_n_o = level_q;

endmodule
`default_nettype wire

// File: rtl/pcileech_sysctl_seq.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_sysctl_seq
// Board reset / power-on sequencer: button reset, config reload, blink, uptime.
// Revision : 1.0 - initial release
// ============================================================================
module pcileech_sysctl_seq
    import pcileech_sysctl_pkg::*;
#(
    parameter int PARAM_DEBOUNCE_CYCLES  = c_def_debounce_cycles,
    parameter int PARAM_RST_CYCLES       = c_def_rst_cycles,
    parameter int PARAM_RELOAD_CYCLES    = c_def_reload_cycles,
    parameter int PARAM_BLINK_BIT        = c_def_blink_bit,
    parameter int PARAM_BLINK_WINDOW_BIT = c_def_blink_window_bit
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_rst_n_i,
    input  logic        btn_led_n_i,
    output logic        rst_out_o,
    output logic        ft601_rst_n_o,
    output logic        rst_cfg_reload_o,
    output logic        led_pwronblink_o,
    output logic [63:0] uptime_o
);

    localparam int                  c_cnt_w     = $clog2(PARAM_RST_CYCLES + 1);
    localparam int                  c_hold_w    = $clog2(PARAM_RELOAD_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_rst_last  = c_cnt_w'(PARAM_RST_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(PARAM_RELOAD_CYCLES - 1);

    logic w_rst_lvl_n;
    logic w_led_lvl_n;
    logic w_rst_pressed;
    logic w_led_pressed;

    sysctl_state_t       state_q,   state_d;
    logic [c_cnt_w-1:0]  cnt_q,     cnt_d;
    logic [c_hold_w-1:0] hold_q,    hold_d;
    logic [63:0]         uptime_q,  uptime_d;
    logic                rst_out_q, rst_out_d;
    logic                reload_q,  reload_d;
    logic                led_q,     led_d;

    pcileech_btn_debounce #(
        .PARAM_DEBOUNCE_CYCLES(PARAM_DEBOUNCE_CYCLES)
    ) u_dbc_rst (
        .clk       (clk),
        .rst       (rst),
        .btn_n_i   (btn_rst_n_i),
        .level_n_o (w_rst_lvl_n)
    );

    pcileech_btn_debounce #(
        .PARAM_DEBOUNCE_CYCLES(PARAM_DEBOUNCE_CYCLES)
    ) u_dbc_led (
        .clk       (clk),
        .rst       (rst),
        .btn_n_i   (btn_led_n_i),
        .level_n_o (w_led_lvl_n)
    );

    assign w_rst_pressed = ~w_rst_lvl_n;
    assign w_led_pressed = ~w_led_lvl_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            hold_q    <= '0;
            uptime_q  <= '0;
            rst_out_q <= 1'b1;
            reload_q  <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            uptime_q  <= uptime_d;
            rst_out_q <= rst_out_d;
            reload_q  <= reload_d;
            led_q     <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: begin
                if (w_rst_pressed)            state_d = S_HELD;
                else if (cnt_q == c_rst_last) state_d = S_RUN;
            end
            S_RUN: begin
                if (w_rst_pressed) state_d = S_HELD;
            end
            S_HELD: begin
                if (!w_rst_pressed)             state_d = S_RESET;
                else if (hold_q == c_hold_last) state_d = S_WAITREL;
            end
            S_WAITREL: begin
                if (!w_rst_pressed) state_d = S_RESET;
            end
            default: state_d = S_RESET;
        endcase
    end

    // Counters clear whenever their state is (re-)entered and only advance
    // while the FSM stays put, so neither can run past its terminal value.
    always_comb begin
        cnt_d     = '0;
        hold_d    = '0;
        uptime_d  = uptime_q;
        rst_out_d = (state_d != S_RUN);
        reload_d  = (state_q == S_HELD) && (state_d == S_WAITREL);
        led_d     = w_led_pressed ^ (uptime_q[PARAM_BLINK_BIT] &
                                     (uptime_q[63:PARAM_BLINK_WINDOW_BIT] == '0));
        if ((state_q == S_RESET) && (state_d == S_RESET)) cnt_d  = cnt_q + 1'b1;
        if ((state_q == S_HELD)  && (state_d == S_HELD))  hold_d = hold_q + 1'b1;
        if ((state_d == S_HELD) || (state_d == S_WAITREL)) begin
            uptime_d = '0;
        end else if ((state_q == S_RESET) || (state_q == S_RUN)) begin
            uptime_d = sat_inc64(uptime_q);
        end
    end

    assign rst_out_o        = rst_out_q;
    assign ft601_rst_n_o    = ~rst_out_q;
    assign rst_cfg_reload_o = reload_q;
    assign led_pwronblink_o = led_q;
    assign uptime_o         = uptime_q;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_sysctl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcileech_sysctl_seq
// Directed + random bench for the sequencer against a timing-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcileech_sysctl_seq;

    localparam int DEB    = 4;
    localparam int RSTC   = 8;
    localparam int RELOAD = 32;
    localparam int BB     = 3;
    localparam int WIN    = 5;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        btn_rst_n = 1'b1;
    logic        btn_led_n = 1'b1;
    logic        rst_out;
    logic        ft601_rst_n;
    logic        rst_cfg_reload;
    logic        led_pwronblink;
    logic [63:0] uptime;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int rsthi    = 0;

    // Model: "held" means the reset button is being honoured (with or
    // without the reload already issued); otherwise a reset sequence is
    // running and its length is read straight off the uptime count.
    bit              m_held;
    bit              m_reloaded;
    int              m_h;
    longint unsigned m_up;
    bit              m_lvl_r;
    bit              m_lvl_l;
    bit              hist_r[$];
    bit              hist_l[$];
    bit              e_rst;
    bit              e_rel;
    bit              e_led;

    pcileech_sysctl_seq #(
        .PARAM_DEBOUNCE_CYCLES  (DEB),
        .PARAM_RST_CYCLES       (RSTC),
        .PARAM_RELOAD_CYCLES    (RELOAD),
        .PARAM_BLINK_BIT        (BB),
        .PARAM_BLINK_WINDOW_BIT (WIN)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_rst_n_i      (btn_rst_n),
        .btn_led_n_i      (btn_led_n),
        .rst_out_o        (rst_out),
        .ft601_rst_n_o    (ft601_rst_n),
        .rst_cfg_reload_o (rst_cfg_reload),
        .led_pwronblink_o (led_pwronblink),
        .uptime_o         (uptime)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A level is accepted once DEB consecutive samples, seen two edges late
    // through the synchronizer, all disagree with the current level.
    function automatic bit settled(input bit q[$], input bit lvl);
        for (int i = 0; i < DEB; i++) begin
            if (q[q.size() - 3 - i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit pr;
        bit pl;
        bit blink;
        if (rst) begin
            m_held = 0; m_reloaded = 0; m_h = 0; m_up = 0;
            m_lvl_r = 1; m_lvl_l = 1;
            hist_r.delete(); hist_l.delete();
            for (int i = 0; i < DEB + 4; i++) begin
                hist_r.push_back(1'b1);
                hist_l.push_back(1'b1);
            end
            e_rst = 1; e_rel = 0; e_led = 0;
        end else begin
            pr    = !m_lvl_r;
            pl    = !m_lvl_l;
            blink = (((m_up >> BB) & 64'd1) != 0) && (m_up < (64'd1 << WIN));
            e_led = pl ^ blink;
            e_rel = 0;
            if (!m_held) begin
                if (pr) begin
                    m_held = 1; m_reloaded = 0; m_h = 0; m_up = 0;
                end else if (m_up != 64'hFFFF_FFFF_FFFF_FFFF) begin
                    m_up = m_up + 1;
                end
            end else if (!pr) begin
                m_held = 0;
                m_up   = 0;
            end else if (!m_reloaded) begin
                if (m_h == RELOAD - 1) begin
                    e_rel      = 1;
                    m_reloaded = 1;
                end else begin
                    m_h++;
                end
            end
            e_rst = m_held || (m_up < RSTC);
            hist_r.push_back(btn_rst_n);
            hist_l.push_back(btn_led_n);
            hist_r.pop_front();
            hist_l.pop_front();
            if (settled(hist_r, m_lvl_r)) m_lvl_r = !m_lvl_r;
            if (settled(hist_l, m_lvl_l)) m_lvl_l = !m_lvl_l;
        end
    endtask

    task automatic tick();
        if (!rst && rst_out === 1'b1)        rsthi++;
        if (!rst && rst_cfg_reload === 1'b1) pulses++;
        @(posedge clk);
        model_edge();
        #1;
        chk("rst_out",        {63'd0, rst_out},        {63'd0, e_rst});
        chk("ft601_rst_n",    {63'd0, ft601_rst_n},    {63'd0, ~e_rst});
        chk("rst_cfg_reload", {63'd0, rst_cfg_reload}, {63'd0, e_rel});
        chk("led_pwronblink", {63'd0, led_pwronblink}, {63'd0, e_led});
        chk("uptime",         uptime,                  m_up);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int len;
        bit do_rst;

        // Power-on reset, then the 8-cycle release sequence.
        rst = 1'b1;
        ticks(3);
        rst   = 1'b0;
        rsthi = 0;
        ticks(20);
        chk("t1_rst_len", rsthi, RSTC);

        // Bounce shorter than the debounce window is ignored.
        rsthi = 0;
        btn_rst_n = 1'b0; ticks(3);
        btn_rst_n = 1'b1; ticks(15);
        chk("t2_no_rst", rsthi, 0);

        // Short hold: reset sequence, no reload.
        pulses = 0;
        btn_rst_n = 1'b0; ticks(20);
        btn_rst_n = 1'b1; ticks(30);
        chk("t3_no_reload", pulses, 0);

        // Long hold: exactly one reload pulse.
        pulses = 0;
        btn_rst_n = 1'b0; ticks(100);
        btn_rst_n = 1'b1; ticks(30);
        chk("t4_one_reload", pulses, 1);

        // Blink window and LED-button inversion.
        ticks(40);
        btn_led_n = 1'b0; ticks(30);
        btn_led_n = 1'b1; ticks(20);

        // Global reset in the middle of a hold aborts it.
        btn_rst_n = 1'b0;
        ticks(DEB + 3 + 20);
        rst = 1'b1; ticks(1);
        rst    = 1'b0;
        pulses = 0;
        ticks(20);
        chk("t6_no_reload", pulses, 0);
        btn_rst_n = 1'b1; ticks(20);

        // Random button activity with occasional global resets.
        for (int it = 0; it < 60; it++) begin
            len       = $urandom_range(1, 60);
            do_rst    = ($urandom % 16) == 0;
            btn_rst_n = ($urandom % 3) != 0;
            btn_led_n = ($urandom % 2) != 0;
            rst       = do_rst;
            ticks(do_rst ? $urandom_range(1, 3) : len);
            rst = 1'b0;
        end
        btn_rst_n = 1'b1;
        btn_led_n = 1'b1;
        ticks(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
